// File: rtl/echo_remover.sv
// Echo remover: x[n] = y[n] - (y[n-DELAY] >>> SHIFT), a sample-driven FIR comb
// over a circular RAM delay line, with saturating output and history gating.
module echo_remover #(
  parameter int DATA_W = 16,
  parameter int DELAY  = 1024,
  parameter int ADDR_W = 10,
  parameter int SHIFT  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] input_echo,
  output logic [DATA_W-1:0] output_clean,
  output logic              output_valid,
  output logic              primed
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DELAY - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DELAY);

  generate
    if (DELAY < 2 || DELAY > (1 << ADDR_W)) begin : g_bad_delay
      $error("echo_remover: DELAY must lie in 2..2**ADDR_W");
    end
  endgenerate

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        s1_addr;
  logic [ADDR_W:0]          fill_cnt;
  logic                     s1_valid;
  logic                     s1_hist;
  logic [DATA_W-1:0]        s1_data;
  logic [DATA_W-1:0]        rd_data;
  logic signed [DATA_W-1:0] echo_full;
  logic signed [DATA_W-1:0] echo;
  logic [DATA_W:0]          diff;
  logic [DATA_W-1:0]        sat_out;
  logic                     accept;

  assign accept = sample_valid & ~clear;
  assign primed = (fill_cnt == FULL_CNT);

  // Read of slot p happens one edge before its overwrite, so the old sample is seen.
  always_ff @(posedge clock) begin
    if (accept)
      rd_data <= mem[wr_ptr];
    if (s1_valid && !clear)
      mem[s1_addr] <= s1_data;
  end

  // Shift kept separate from the gating mux so the shift stays arithmetic.
  always_comb begin
    echo_full = $signed(rd_data) >>> SHIFT;
    echo      = s1_hist ? echo_full : '0;
    diff      = {s1_data[DATA_W-1], s1_data} - {echo[DATA_W-1], echo};
    sat_out   = diff[DATA_W-1:0];
    if (diff[DATA_W] != diff[DATA_W-1])
      sat_out = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      s1_valid     <= 1'b0;
      s1_hist      <= 1'b0;
      s1_addr      <= '0;
      s1_data      <= '0;
      output_clean <= '0;
      output_valid <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      s1_valid     <= 1'b0;
      output_valid <= 1'b0;
    end else begin
      s1_valid     <= sample_valid;
      output_valid <= s1_valid;
      if (s1_valid)
        output_clean <= sat_out;
      if (sample_valid) begin
        s1_data <= input_echo;
        s1_addr <= wr_ptr;
        s1_hist <= (fill_cnt == FULL_CNT);
        wr_ptr  <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (fill_cnt != FULL_CNT)
          fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/echo_remover.md
Name: echo_remover

Overview:
- Inverse of the feedback echo stage. It removes a single attenuated echo from a 16-bit audio stream by computing x[n] = y[n] − (y[n−DELAY] >>> SHIFT).
- It is a sample-driven FIR comb on a circular RAM delay line.
- Sits on the receive/analysis path of the DSP chain, ahead of the codec output or downstream filters.

Parameters:
- DATA_W, 16, sample width (two's complement).
- DELAY, 1024, echo distance in accepted samples; legal range 2..2^ADDR_W.
- ADDR_W, 10, delay-line address width.
- SHIFT, 2, echo attenuation as an arithmetic right shift (gain 2^−SHIFT).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of history and pipeline.
- sample_valid  in  1  qualifies input_echo for one cycle.
- input_echo  in  DATA_W  echo-laden sample y[n].
- output_clean  out  DATA_W  recovered sample x[n].
- output_valid  out  1  one-cycle strobe qualifying output_clean.
- primed  out  1  high once DELAY samples have been accepted since reset/clear.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - output_clean=0, output_valid=0, primed=0.
  - wr_ptr=0, fill_cnt=0, pipeline valids=0.
  - RAM contents are not cleared.
- Delay counts accepted samples, not clocks. Idle cycles (sample_valid=0) hold all state; no output strobe is produced.
- Pipeline, for a sample accepted at cycle T:
  - Stage 1 (T): register input_echo and wr_ptr; issue synchronous RAM read at wr_ptr, which returns y[n−DELAY].
  - Stage 2 (T+1): form the echo term; write the registered sample to RAM at the same address (read-before-write); advance the pointer.
  - Output registered at T+2: output_valid=1 for exactly one cycle.
  - Latency is 2 clocks. Throughput is one sample per clock.
- Pointer: wr_ptr increments per accepted sample and wraps from DELAY−1 to 0 (not 2^ADDR_W−1 unless DELAY=2^ADDR_W).
- History gating: fill_cnt saturates at DELAY. While fill_cnt<DELAY at stage 1, the echo term is forced to 0 (stale RAM ignored), so output = input for the first DELAY samples. primed = (fill_cnt==DELAY).
- Arithmetic:
  - echo = sign-extended y_old >>> SHIFT (floor toward −inf, e.g. −3>>>2 = −1).
  - diff = {in[15],in} − {echo[15],echo}, computed at 17 bits.
  - Saturate to [−32768, +32767]; no wrap.
- Back-to-back samples: a stage-2 write at p and a stage-1 read at p+1 never collide for DELAY≥2. DELAY<2 is illegal; an assertion fires at elaboration.
- clear=1 (synchronous, priority over sample_valid):
  - wr_ptr=0, fill_cnt=0, primed=0.
  - In-flight stage valids dropped; output_valid=0 next cycle.
  - output_clean holds its last value.
  - A sample presented in the same cycle is discarded.
- Reset mid-stream: same as clear but asynchronous, and output_clean returns to 0. The first DELAY post-reset samples pass through unmodified regardless of RAM contents.
- output_clean is only meaningful when output_valid=1 and holds its value between strobes.

Test Plan:
- DELAY=4, SHIFT=2: impulse 4000 at sample 0, then zeros -> outputs 4000,0,0,0,−1000,0…; each output_valid exactly 2 clocks after its sample_valid.
- Round trip: drive the echo-stage output for x = impulse 4000 (y = 4000, 0,0,0, 1000, 0,0,0, 250…) -> output 4000 then all zeros.
- Saturation:
  - y_old=32767, then in=−32768 -> echo 8191, out=−32768 (not wrapped).
  - y_old=−32768, then in=32767 -> out=32767.
- Valid gaps: 4 samples with 3 idle clocks between each -> echo still aligns to sample index n−4; no output_valid on idle cycles; primed rises with the 4th accepted sample.
- clear after 6 samples with a sample in flight -> the in-flight output is suppressed; the next 4 samples pass unchanged (stale RAM ignored); primed=0 until the 4th.
- Async reset asserted mid-burst between clock edges -> all outputs 0 immediately; after release, behaviour matches a fresh start.
